keypad_scan_ctrl: RTL and testbench
===================================

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_CYCLES, default 4, clk cycles each column is driven before advancing (>=2).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 2400000, clk cycles a level must be stable to be accepted (>=2).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rows  input  4  keypad row lines, active-low, already synchronized externally.
REQ-006 SHALL have port cols  output  4  keypad column drive, active-low one-hot.
REQ-007 SHALL have port key  output  4  code of the last accepted key, {col_idx[1:0], row_idx[1:0]}.
REQ-008 SHALL have port key_valid  output  1  one-cycle pulse when a new key is accepted.

Function
REQ-009 SHALL implement FSM states SCAN, DB_PRESS, HELD, DB_RELEASE.
REQ-010 SCAN: drive cols low on col_idx only; a SCAN_CYCLES-wide dwell counter runs; at dwell end with rows==4'hF, col_idx SHALL advance 0->1->2->3->0 (wrap) and the dwell counter SHALL clear.
REQ-011 SCAN: rows!=4'hF sampled on the last dwell cycle SHALL latch col_idx and row_idx (lowest-index low row wins), clear the debounce counter, go to DB_PRESS; cols SHALL stay frozen on the latched column.
REQ-012 DB_PRESS: the debounce counter increments each cycle while rows[row_idx] stays low; if rows[row_idx] goes high, the FSM SHALL return to SCAN with col_idx advanced by one and no output change.
REQ-013 DB_PRESS: when the counter reaches DEBOUNCE_CYCLES-1 with rows[row_idx] still low, the FSM SHALL enter HELD, load key={col_idx,row_idx}, and assert key_valid for exactly that one cycle.
REQ-014 HELD: cols frozen; other rows or keys going low SHALL be ignored; rows[row_idx] going high SHALL clear the debounce counter and enter DB_RELEASE.
REQ-015 DB_RELEASE: each cycle rows[row_idx] is high the counter increments; any low sample SHALL clear the counter and return to HELD without a key_valid pulse.
REQ-016 DB_RELEASE: counter reaching DEBOUNCE_CYCLES-1 with the row still high SHALL return to SCAN at col_idx+1 (wrap 3->0), dwell counter cleared.
REQ-017 key SHALL hold its value until the next accepted key; key_valid SHALL never be high for two consecutive cycles.
REQ-018 A key accepted on a repeated press of the same button SHALL pulse key_valid again.
REQ-019 Debounce counter width SHALL be $clog2(DEBOUNCE_CYCLES) bits and SHALL never wrap past DEBOUNCE_CYCLES-1.
REQ-020 cols SHALL always be one-hot-low (exactly one bit 0), including during and after reset.

Reset
REQ-021 reset high at a posedge SHALL force state SCAN, col_idx=0, cols=4'b1110, key=4'h0, key_valid=0, both counters 0, in any state.
REQ-022 reset asserted mid-DB_PRESS or mid-HELD SHALL suppress any pending key_valid; after release scanning SHALL restart at column 0.

Verification (SCAN_CYCLES=2, DEBOUNCE_CYCLES=8)
REQ-023 reset 1 then 0, rows=4'hF -> cols cycles 1110,1101,1011,0111,1110 every 2 clk; key=0, key_valid=0 throughout.
REQ-024 rows[2] held low while cols==1101 for 20 clk -> key_valid single pulse 8 clk after detection, key=4'b0110, cols stuck at 1101 while held.
REQ-025 rows[1] low for 3 clk then high during DB_PRESS at col 3 -> no key_valid, scanning resumes at col 0 (cols=1110).
REQ-026 held key releases with 3-clk glitch low in DB_RELEASE -> counter restarts, no second pulse; after 8 stable high clk scanning resumes at next column.
REQ-027 rows[0] and rows[3] both low on col 2 -> key=4'b1000; second key pressed while HELD -> ignored, no pulse.
REQ-028 reset asserted 4 clk into DB_PRESS -> key_valid never asserts, cols=1110 next cycle, key=0.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: walks active-low columns, debounces press and
// release of one key, and emits a one-cycle key_valid pulse per accepted press.
module keypad_scan_ctrl #(
    parameter int SCAN_CYCLES     = 4,
    parameter int DEBOUNCE_CYCLES = 2400000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key,
    output logic       key_valid
);

    localparam int SW = (SCAN_CYCLES > 2) ? $clog2(SCAN_CYCLES) : 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES);

    localparam logic [SW-1:0] DWELL_LAST = SW'(SCAN_CYCLES - 1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] SCAN       = 2'd0;
    localparam logic [1:0] DB_PRESS   = 2'd1;
    localparam logic [1:0] HELD       = 2'd2;
    localparam logic [1:0] DB_RELEASE = 2'd3;

    logic [1:0]    state;
    logic [1:0]    col_idx;
    logic [1:0]    row_idx;
    logic [1:0]    low_row;
    logic [SW-1:0] dwell;
    logic [DW-1:0] db_cnt;
    logic          row_low;

    // Column drive derives from col_idx alone, so it is one-hot-low even in reset.
    assign cols    = ~(4'b0001 << col_idx);
    assign row_low = ~rows[row_idx];

    always_comb begin
        low_row = 2'd0;
        if (!rows[0])      low_row = 2'd0;
        else if (!rows[1]) low_row = 2'd1;
        else if (!rows[2]) low_row = 2'd2;
        else if (!rows[3]) low_row = 2'd3;
    end

    always_ff @(posedge clk) begin
        key_valid <= 1'b0;
        if (reset) begin
            state   <= SCAN;
            col_idx <= 2'd0;
            row_idx <= 2'd0;
            dwell   <= '0;
            db_cnt  <= '0;
            key     <= 4'h0;
        end else begin
            unique case (state)
                SCAN: begin
                    if (dwell == DWELL_LAST) begin
                        dwell <= '0;
                        if (rows == 4'hF) begin
                            col_idx <= col_idx + 2'd1;
                        end else begin
                            row_idx <= low_row;
                            db_cnt  <= '0;
                            state   <= DB_PRESS;
                        end
                    end else begin
                        dwell <= dwell + 1'b1;
                    end
                end
                DB_PRESS: begin
                    if (!row_low) begin
                        col_idx <= col_idx + 2'd1;
                        dwell   <= '0;
                        state   <= SCAN;
                    end else if (db_cnt == DB_LAST) begin
                        key       <= {col_idx, row_idx};
                        key_valid <= 1'b1;
                        state     <= HELD;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!row_low) begin
                        db_cnt <= '0;
                        state  <= DB_RELEASE;
                    end
                end
                DB_RELEASE: begin
                    if (row_low) begin
                        db_cnt <= '0;
                        state  <= HELD;
                    end else if (db_cnt == DB_LAST) begin
                        col_idx <= col_idx + 2'd1;
                        dwell   <= '0;
                        state   <= SCAN;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a modelled 4x4 key matrix drives rows from cols;
// expected key codes are queued on press and matched against key_valid pulses.
module tb_keypad_scan_ctrl;

    localparam int SC = 2;
    localparam int DC = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key;
    logic       key_valid;

    logic [3:0] pressed [4];
    logic [3:0] exp_q [$];
    logic       prev_kv = 1'b0;
    logic       mon_en = 1'b0;
    int         tests = 0;
    int         fails = 0;

    keypad_scan_ctrl #(
        .SCAN_CYCLES(SC),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rows(rows),
        .cols(cols),
        .key(key),
        .key_valid(key_valid)
    );

    always #5 clk = ~clk;

    // A pressed key pulls its row low only while its column is driven low.
    always_comb begin
        rows = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (pressed[c][r] && !cols[c]) rows[r] = 1'b0;
    end

    task automatic tick();
        logic [3:0] e;
        @(negedge clk);
        if (mon_en) begin
            tests++;
            if ($countones(~cols) != 1) begin
                fails++;
                $display("FAIL cols_onehot got %b", cols);
            end
            if (key_valid) begin
                tests++;
                if (prev_kv) begin
                    fails++;
                    $display("FAIL kv_double key_valid high two cycles");
                end
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_pulse key=%h want no pulse", key);
                end else begin
                    e = exp_q.pop_front();
                    if (key !== e) begin
                        fails++;
                        $display("FAIL pulse_key got %h want %h", key, e);
                    end
                end
            end
        end
        prev_kv = key_valid;
    endtask

    task automatic wait_col(input logic [3:0] t);
        int n;
        n = 0;
        while (cols == t && n < 40) begin tick(); n++; end
        while (cols != t && n < 40) begin tick(); n++; end
        tests++;
        if (cols !== t) begin
            fails++;
            $display("FAIL wait_col got %b want %b", cols, t);
        end
    endtask

    task automatic wait_pulse(input int lat, input string nm);
        int n;
        n = 0;
        do begin tick(); n++; end while (!key_valid && n < 30);
        tests++;
        if (!key_valid || n != lat) begin
            fails++;
            $display("FAIL %s pulse after %0d clk (seen=%b) want %0d", nm, n, key_valid, lat);
        end
    endtask

    task automatic wait_release(input logic [3:0] from, input logic [3:0] to,
                                input int lat, input string nm);
        int n;
        n = 0;
        do begin tick(); n++; end while (cols == from && n < 40);
        tests++;
        if (cols !== to || n != lat) begin
            fails++;
            $display("FAIL %s cols=%b after %0d clk want %b after %0d", nm, cols, n, to, lat);
        end
    endtask

    task automatic release_all();
        for (int c = 0; c < 4; c++) pressed[c] = 4'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        tests++;
        if (cols !== 4'b1110) begin fails++; $display("FAIL reset_cols got %b want 1110", cols); end
        tests++;
        if (key !== 4'h0) begin fails++; $display("FAIL reset_key got %h want 0", key); end
        tests++;
        if (key_valid !== 1'b0) begin fails++; $display("FAIL reset_kv got %b want 0", key_valid); end
        mon_en = 1'b1;
    endtask

    task automatic test_scan();
        logic [3:0] e;
        reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            e = ~(4'b0001 << ((k / 2) % 4));
            tests++;
            if (cols !== e) begin
                fails++;
                $display("FAIL scan_cols step %0d got %b want %b", k, cols, e);
            end
            tests++;
            if (key !== 4'h0 || key_valid !== 1'b0) begin
                fails++;
                $display("FAIL scan_idle key=%h kv=%b want 0/0", key, key_valid);
            end
        end
    endtask

    task automatic test_press();
        wait_col(4'b1101);
        pressed[1][2] = 1'b1;
        exp_q.push_back(4'b0110);
        wait_pulse(10, "press_1_2");
        for (int i = 0; i < 10; i++) begin
            tick();
            tests++;
            if (cols !== 4'b1101 || key !== 4'b0110) begin
                fails++;
                $display("FAIL held_freeze cols=%b key=%h want 1101/6", cols, key);
            end
        end
        pressed[1][2] = 1'b0;
        wait_release(4'b1101, 4'b1011, 9, "release_1_2");
        tests++;
        if (exp_q.size() != 0 || key !== 4'b0110) begin
            fails++;
            $display("FAIL press_after key=%h pending=%0d want 6/0", key, exp_q.size());
        end
    endtask

    task automatic test_abort();
        wait_col(4'b0111);
        pressed[3][1] = 1'b1;
        repeat (5) tick();
        tests++;
        if (cols !== 4'b0111) begin fails++; $display("FAIL abort_frozen got %b want 0111", cols); end
        pressed[3][1] = 1'b0;
        tick();
        tests++;
        if (cols !== 4'b1110) begin fails++; $display("FAIL abort_resume got %b want 1110", cols); end
        repeat (6) tick();
        tests++;
        if (key !== 4'b0110) begin fails++; $display("FAIL abort_key got %h want 6", key); end
    endtask

    task automatic test_multi_glitch();
        wait_col(4'b1011);
        pressed[2][0] = 1'b1;
        pressed[2][3] = 1'b1;
        exp_q.push_back(4'b1000);
        wait_pulse(10, "press_2_0and3");
        pressed[0][1] = 1'b1;
        pressed[2][2] = 1'b1;
        repeat (6) tick();
        tests++;
        if (key !== 4'b1000 || cols !== 4'b1011) begin
            fails++;
            $display("FAIL held_ignore key=%h cols=%b want 8/1011", key, cols);
        end
        release_all();
        repeat (3) tick();
        pressed[2][0] = 1'b1;
        repeat (3) tick();
        tests++;
        if (cols !== 4'b1011) begin fails++; $display("FAIL glitch_frozen got %b want 1011", cols); end
        pressed[2][0] = 1'b0;
        wait_release(4'b1011, 4'b0111, 9, "glitch_release");
        tests++;
        if (exp_q.size() != 0) begin fails++; $display("FAIL multi_pending got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            wait_col(4'b1110);
            pressed[0][3] = 1'b1;
            exp_q.push_back(4'b0011);
            wait_pulse(10, "repeat_0_3");
            repeat (2) tick();
            pressed[0][3] = 1'b0;
            wait_release(4'b1110, 4'b1101, 9, "repeat_release");
        end
        tests++;
        if (exp_q.size() != 0 || key !== 4'b0011) begin
            fails++;
            $display("FAIL repeat_after key=%h pending=%0d want 3/0", key, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        wait_col(4'b1101);
        pressed[1][1] = 1'b1;
        repeat (6) tick();
        reset = 1'b1;
        tick();
        tests++;
        if (cols !== 4'b1110 || key !== 4'h0 || key_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset cols=%b key=%h kv=%b want 1110/0/0", cols, key, key_valid);
        end
        pressed[1][1] = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        tests++;
        if (cols !== 4'b1110) begin fails++; $display("FAIL mid_restart got %b want 1110", cols); end
        repeat (20) tick();
        tests++;
        if (key !== 4'h0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL mid_after key=%h pending=%0d want 0/0", key, exp_q.size());
        end
    endtask

    initial begin
        release_all();
        test_reset();
        test_scan();
        test_press();
        test_abort();
        test_multi_glitch();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
